// File: rtl/avmm_pio_multi.sv
// ============================================================================
// Module   : avmm_pio_multi
// Purpose  : Avalon-MM PIO with synchronised, optionally debounced (define
//            PIO_DEBOUNCE_EN) edge-capturing inputs, maskable IRQ and atomic
//            set/clear outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avmm_pio_multi #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out
);

    localparam logic [2:0] ADDR_DATA_IN   = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET   = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR   = 3'd5;
    localparam logic [2:0] ADDR_EDGE_RISE = 3'd6;
    localparam logic [2:0] ADDR_EDGE_FALL = 3'd7;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] data_out_q,  data_out_d;
    logic [WIDTH-1:0] irq_mask_q,  irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q,  edge_cap_d;
    logic [WIDTH-1:0] edge_rise_q, edge_rise_d;
    logic [WIDTH-1:0] edge_fall_q, edge_fall_d;
    logic [31:0]      readdata_q,  readdata_d;

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_word;

    assign w_wd = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

`ifdef PIO_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Each bit follows sync2 only after it has differed for DEBOUNCE_CYCLES clocks.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_deb
            logic [CNT_W-1:0] cnt_q;
            logic             deb_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (sync2_q[i] != deb_q) begin
                    if (cnt_q == CNT_LAST) begin
                        deb_q <= sync2_q[i];
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign w_deb[i] = deb_q;
        end
    endgenerate
`else
    logic w_unused_deb;
    assign w_unused_deb = (DEBOUNCE_CYCLES > 0);
    assign w_deb        = sync2_q;
`endif

    assign w_rise = w_deb & ~prev_q & edge_rise_q;
    assign w_fall = ~w_deb & prev_q & edge_fall_q;

    always_comb begin
        data_out_d  = data_out_q;
        irq_mask_d  = irq_mask_q;
        edge_rise_d = edge_rise_q;
        edge_fall_d = edge_fall_q;
        w_clr       = '0;
        if (write) begin
            case (address)
                ADDR_DATA_OUT:  data_out_d  = w_wd;
                ADDR_IRQ_MASK:  irq_mask_d  = w_wd;
                ADDR_EDGE_CAP:  w_clr       = w_wd;
                ADDR_OUT_SET:   data_out_d  = data_out_q | w_wd;
                ADDR_OUT_CLR:   data_out_d  = data_out_q & ~w_wd;
                ADDR_EDGE_RISE: edge_rise_d = w_wd;
                ADDR_EDGE_FALL: edge_fall_d = w_wd;
                default:        ;
            endcase
        end
        // New edges are OR'd in after the clear so a same-cycle set survives.
        edge_cap_d = (edge_cap_q & ~w_clr) | w_rise | w_fall;
    end

    // Read mux sees the current register contents, so a concurrent write
    // returns the pre-write value.
    always_comb begin
        w_rd_word = '0;
        case (address)
            ADDR_DATA_IN:   w_rd_word[WIDTH-1:0] = w_deb;
            ADDR_DATA_OUT:  w_rd_word[WIDTH-1:0] = data_out_q;
            ADDR_IRQ_MASK:  w_rd_word[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP:  w_rd_word[WIDTH-1:0] = edge_cap_q;
            ADDR_EDGE_RISE: w_rd_word[WIDTH-1:0] = edge_rise_q;
            ADDR_EDGE_FALL: w_rd_word[WIDTH-1:0] = edge_fall_q;
            default:        w_rd_word = '0;
        endcase
        readdata_d = read ? w_rd_word : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            data_out_q  <= OUT_RESET;
            irq_mask_q  <= '0;
            edge_cap_q  <= '0;
            edge_rise_q <= '0;
            edge_fall_q <= '0;
            readdata_q  <= '0;
        end else begin
            sync1_q     <= pio_in;
            sync2_q     <= sync1_q;
            prev_q      <= w_deb;
            data_out_q  <= data_out_d;
            irq_mask_q  <= irq_mask_d;
            edge_cap_q  <= edge_cap_d;
            edge_rise_q <= edge_rise_d;
            edge_fall_q <= edge_fall_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign pio_out  = data_out_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

`default_nettype wire

// File: tb/tb_avmm_pio_multi.sv
// ============================================================================
// Module   : tb_avmm_pio_multi
// Purpose  : Self-checking bench for avmm_pio_multi (register table plus
//            timed sequences for edge capture, debounce and async reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avmm_pio_multi;

    localparam int DC = 4;
`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  pio_in;
    logic [7:0]  pio_out;

    int n_cmp;
    int n_err;

    avmm_pio_multi #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DC),
        .OUT_RESET       (8'hA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .pio_in    (pio_in),
        .pio_out   (pio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vec [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = readdata;
    endtask

    logic [31:0] d;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        pio_in    = '0;

        vec[0]  = '{1'b0, 3'd1, 32'h0,         32'hA5, 8'hA5};
        vec[1]  = '{1'b0, 3'd3, 32'h0,         32'h00, 8'hA5};
        vec[2]  = '{1'b1, 3'd4, 32'h0F,        32'h00, 8'hAF};
        vec[3]  = '{1'b1, 3'd5, 32'hA0,        32'h00, 8'h0F};
        vec[4]  = '{1'b0, 3'd1, 32'h0,         32'h0F, 8'h0F};
        vec[5]  = '{1'b1, 3'd1, 32'h1234_5633, 32'h00, 8'h33};
        vec[6]  = '{1'b0, 3'd1, 32'h0,         32'h33, 8'h33};
        vec[7]  = '{1'b1, 3'd2, 32'hFF,        32'h00, 8'h33};
        vec[8]  = '{1'b0, 3'd2, 32'h0,         32'hFF, 8'h33};
        vec[9]  = '{1'b1, 3'd2, 32'h01,        32'h00, 8'h33};
        vec[10] = '{1'b0, 3'd2, 32'h0,         32'h01, 8'h33};
        vec[11] = '{1'b0, 3'd4, 32'h0,         32'h00, 8'h33};
        vec[12] = '{1'b0, 3'd5, 32'h0,         32'h00, 8'h33};
        vec[13] = '{1'b1, 3'd6, 32'hFFFF_FF01, 32'h00, 8'h33};
        vec[14] = '{1'b0, 3'd6, 32'h0,         32'h01, 8'h33};
        vec[15] = '{1'b1, 3'd7, 32'h02,        32'h00, 8'h33};
        vec[16] = '{1'b0, 3'd7, 32'h0,         32'h02, 8'h33};
        vec[17] = '{1'b0, 3'd0, 32'h0,         32'h00, 8'h33};
        vec[18] = '{1'b1, 3'd0, 32'hFF,        32'h00, 8'h33};
        vec[19] = '{1'b0, 3'd0, 32'h0,         32'h00, 8'h33};
        vec[20] = '{1'b1, 3'd3, 32'hFF,        32'h00, 8'h33};
        vec[21] = '{1'b0, 3'd3, 32'h0,         32'h00, 8'h33};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_pio_out", {24'h0, pio_out}, 32'hA5);
        reset_n = 1'b1;
        @(negedge clk);

        // Register table
        for (int i = 0; i < 22; i++) begin
            if (vec[i].wr) begin
                wr(vec[i].addr, vec[i].wd);
            end else begin
                rd(vec[i].addr, d);
                chk($sformatf("tbl%0d_readdata", i), d, vec[i].exp_rd);
            end
            chk($sformatf("tbl%0d_pio_out", i), {24'h0, pio_out}, {24'h0, vec[i].exp_out});
            chk($sformatf("tbl%0d_irq", i), {31'h0, irq}, 32'h0);
        end

        // Read and write same cycle returns the old value
        address   = 3'd1;
        writedata = 32'h55;
        read      = 1'b1;
        write     = 1'b1;
        @(negedge clk);
        read      = 1'b0;
        write     = 1'b0;
        chk("rw_old_value", readdata, 32'h33);
        chk("rw_pio_out", {24'h0, pio_out}, 32'h55);
        rd(3'd1, d);
        chk("rw_readback", d, 32'h55);

        // Rising edge on bit 0 -> irq LAT+1 clocks after the pin change
        pio_in = 8'h01;
        repeat (LAT) @(negedge clk);
        chk("rise_irq_early", {31'h0, irq}, 32'h0);
        rd(3'd0, d);
        chk("rise_data_in", d, 32'h01);
        chk("rise_irq", {31'h0, irq}, 32'h1);
        rd(3'd3, d);
        chk("rise_edge_cap", d, 32'h01);
        wr(3'd3, 32'h01);
        chk("w1c_irq_low", {31'h0, irq}, 32'h0);
        rd(3'd3, d);
        chk("w1c_edge_cap", d, 32'h00);

        // Bit 1 high, then 3-clock low glitch
        pio_in = 8'h03;
        repeat (LAT + 2) @(negedge clk);
        rd(3'd0, d);
        chk("bit1_high_data_in", d, 32'h03);
        rd(3'd3, d);
        chk("bit1_high_cap", d, 32'h00);
        pio_in = 8'h01;
        repeat (3) @(negedge clk);
        pio_in = 8'h03;
        repeat (LAT + 6) @(negedge clk);
        rd(3'd0, d);
        chk("glitch_data_in", d, 32'h03);
        rd(3'd3, d);
`ifdef PIO_DEBOUNCE_EN
        chk("glitch_cap", d, 32'h00);
`else
        chk("glitch_cap", d, 32'h02);
`endif
        wr(3'd3, 32'h02);
        wr(3'd2, 32'h03);
        chk("pre_fall_irq", {31'h0, irq}, 32'h0);

        // Held low on bit 1 -> DATA_IN after LAT, EDGE_CAP after LAT+1
        pio_in = 8'h01;
        repeat (LAT - 1) @(negedge clk);
        rd(3'd0, d);
        chk("fall_data_in_early", d, 32'h03);
        chk("fall_irq_early", {31'h0, irq}, 32'h0);
        rd(3'd0, d);
        chk("fall_data_in", d, 32'h01);
        chk("fall_irq", {31'h0, irq}, 32'h1);
        rd(3'd3, d);
        chk("fall_cap", d, 32'h02);
        wr(3'd3, 32'h02);
        chk("fall_clr_irq", {31'h0, irq}, 32'h0);

        // Rise and W1C of the same bit on the same clock: set wins
        pio_in = 8'h00;
        repeat (LAT + 2) @(negedge clk);
        rd(3'd3, d);
        chk("setwins_pre_cap", d, 32'h00);
        pio_in = 8'h01;
        repeat (LAT) @(negedge clk);
        wr(3'd3, 32'h01);
        chk("setwins_irq", {31'h0, irq}, 32'h1);
        rd(3'd3, d);
        chk("setwins_cap", d, 32'h01);

        // All bits captured, then async reset mid debounce count
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        wr(3'd2, 32'hFF);
        pio_in = 8'hFE;
        repeat (LAT + 2) @(negedge clk);
        rd(3'd3, d);
        chk("all_cap", d, 32'hFF);
        chk("all_irq", {31'h0, irq}, 32'h1);
        pio_in = 8'h5A;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_irq", {31'h0, irq}, 32'h0);
        chk("async_pio_out", {24'h0, pio_out}, 32'hA5);
        chk("async_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        rd(3'd0, d);
        chk("post_reset_data_in_early", d, 32'h00);
        rd(3'd0, d);
        chk("post_reset_data_in", d, 32'h5A);
        rd(3'd3, d);
        chk("post_reset_cap", d, 32'h00);
        rd(3'd1, d);
        chk("post_reset_data_out", d, 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
